// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared constants and types for the instruction-fetch controller.
package ifu_fetch_ctrl_pkg;

  localparam logic       RST_ENABLE    = 1'b0;
  localparam logic       BRANCH_ENABLE = 1'b1;
  localparam int         INST_ADDR_BUS = 32;
  localparam int         INST_DATA_BUS = 32;
  localparam logic [1:0] RESP_OKAY     = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    AR   = 2'b01,
    R    = 2'b10,
    OUT  = 2'b11
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'b00,
    PC_SEQ   = 2'b01,
    PC_DNPC  = 2'b10,
    PC_REDIR = 2'b11
  } pc_sel_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// PC register with pending-redirect storage; the FSM chooses how pc advances.
module ifu_pc_reg
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_BUS,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  pc_sel_e           pc_sel,
  input  logic              capture,
  input  logic              flush_clr,
  input  logic [ADDR_W-1:0] dnpc,
  output logic [ADDR_W-1:0] pc,
  output logic              flush
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

  logic [ADDR_W-1:0] redir_pc;

  // capture wins over flush_clr so a redirect arriving with the flushed beat is never lost
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      pc       <= RESET_PC;
      redir_pc <= '0;
      flush    <= 1'b0;
    end else begin
      case (pc_sel)
        PC_SEQ:   pc <= pc + PC_STEP;
        PC_DNPC:  pc <= dnpc;
        PC_REDIR: pc <= redir_pc;
        default:  pc <= pc;
      endcase
      if (capture) begin
        redir_pc <= dnpc;
        flush    <= 1'b1;
      end else if (flush_clr) begin
        flush    <= 1'b0;
      end else begin
        flush    <= flush;
      end
    end
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding AR/R read, IDU handshake, branch redirect.
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_BUS,
  parameter int                DATA_W   = INST_DATA_BUS,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              be,
  input  logic [ADDR_W-1:0] dnpc,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              err_o,
  output logic              valid_o,
  input  logic              ready_i
);

  fetch_state_e      state;
  fetch_state_e      next_state;
  pc_sel_e           pc_sel;
  logic              capture;
  logic              flush_clr;
  logic              take_data;
  logic              flush;
  logic [ADDR_W-1:0] pc;

  ifu_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .pc_sel    (pc_sel),
    .capture   (capture),
    .flush_clr (flush_clr),
    .dnpc      (dnpc),
    .pc        (pc),
    .flush     (flush)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next state plus pc/flush control; a redirect always beats the sequential pc+4
  always_comb begin
    next_state = state;
    pc_sel     = PC_HOLD;
    capture    = 1'b0;
    flush_clr  = 1'b0;
    take_data  = 1'b0;
    case (state)
      IDLE: begin
        next_state = AR;
        if (be == BRANCH_ENABLE) begin
          pc_sel = PC_DNPC;
        end else begin
          pc_sel = PC_HOLD;
        end
      end
      AR: begin
        capture = (be == BRANCH_ENABLE);
        if (arready) begin
          next_state = R;
        end else begin
          next_state = AR;
        end
      end
      R: begin
        if (rvalid) begin
          flush_clr = 1'b1;
          if (be == BRANCH_ENABLE) begin
            pc_sel     = PC_DNPC;
            next_state = AR;
          end else if (flush) begin
            pc_sel     = PC_REDIR;
            next_state = AR;
          end else begin
            take_data  = 1'b1;
            next_state = OUT;
          end
        end else begin
          capture    = (be == BRANCH_ENABLE);
          next_state = R;
        end
      end
      OUT: begin
        if (be == BRANCH_ENABLE) begin
          pc_sel     = PC_DNPC;
          next_state = AR;
        end else if (ready_i) begin
          pc_sel     = PC_SEQ;
          next_state = AR;
        end else begin
          next_state = OUT;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // handshake outputs decode the state register only, so no input reaches them combinationally
  always_comb begin
    araddr  = pc;
    arvalid = 1'b0;
    rready  = 1'b0;
    valid_o = 1'b0;
    case (state)
      AR:      arvalid = 1'b1;
      R:       rready  = 1'b1;
      OUT:     valid_o = 1'b1;
      default: arvalid = 1'b0;
    endcase
  end

  // instruction hold registers
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      inst_o <= '0;
      pc_o   <= '0;
      err_o  <= 1'b0;
    end else if (take_data) begin
      inst_o <= rdata;
      pc_o   <= pc;
      err_o  <= resp_is_err(rresp);
    end else begin
      inst_o <= inst_o;
      pc_o   <= pc_o;
      err_o  <= err_o;
    end
  end

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
Instruction-fetch sequencer on the consuming side of the next-PC selection. It owns the PC register and issues one instruction read at a time on an AXI-lite-style AR/R channel pair. It presents each fetched instruction to the IDU through a valid/ready handshake. It accepts a branch redirect (be/dnpc) from the EXU and selects RESET_PC, dnpc or pc+4 as the next fetch address.

Parameters:
RESET_PC, 32'h8000_0000, first fetch address after reset
ADDR_W, 32, PC / address width
DATA_W, 32, instruction width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
be  input  1  branch redirect pulse from EXU, one cycle
dnpc  input  ADDR_W  redirect target, sampled when be=1
araddr  output  ADDR_W  fetch address
arvalid  output  1  read-address valid
arready  input  1  read-address ready
rdata  input  DATA_W  read data
rresp  input  2  read response, 2'b00 = OKAY
rvalid  input  1  read-data valid
rready  output  1  read-data ready
inst_o  output  DATA_W  fetched instruction to IDU
pc_o  output  ADDR_W  PC of inst_o
err_o  output  1  fetch error flag, qualified by valid_o
valid_o  output  1  instruction valid to IDU
ready_i  input  1  IDU ready

Behaviour:
- Reset (rst=0, asynchronous):
  - pc = RESET_PC, state = IDLE, flush = 0
  - arvalid = rready = valid_o = err_o = 0
  - inst_o = 0, pc_o = 0
  - An in-flight transaction is abandoned; the memory slave shares rst.
- States and transitions:
  - IDLE: arvalid=0. Next cycle -> AR.
  - AR: arvalid=1, araddr=pc. araddr is held stable until arready. On arvalid&arready -> R.
  - R: rready=1. On rvalid:
    - flush=0: latch inst_o=rdata, pc_o=pc, err_o=(rresp!=0), then -> OUT.
    - flush=1: discard data, clear flush, pc=redir_pc, then -> AR.
  - OUT: valid_o=1; inst_o, pc_o, err_o held stable. On valid_o&ready_i: pc=pc+4 (wraps modulo 2^ADDR_W), then -> AR.
- Fetch-to-valid latency: 1 cycle after the AR handshake when rvalid is asserted the same cycle that rready rises. Minimum loop is 3 cycles per instruction (AR, R, OUT).
- Redirect (be=1) handling, in every state:
  - AR with handshake not done: araddr must not change. Set flush and store redir_pc=dnpc; the handshake completes normally.
  - AR with handshake done the same cycle: same action, go to R with flush=1.
  - R: set flush, store redir_pc=dnpc. If rvalid is asserted the same cycle, the data is discarded immediately and the next state is AR with pc=dnpc.
  - OUT: drop valid_o next cycle, pc=dnpc, -> AR. This holds even when ready_i=1 in the same cycle: redirect wins over the sequential pc+4 and the IDU handshake completes. The EXU guarantees that instruction is on the correct path.
  - IDLE: pc=dnpc, -> AR.
- A second be while flush=1 overwrites redir_pc; the last redirect wins.
- dnpc[1:0]!=0: fetched as given. The slave returns an error response, and err_o propagates with valid_o.
- No combinational path from ready_i or rvalid to arvalid. valid_o is a registered output.

Decomposition:
- Shared defines: RST_ENABLE (1'b0), BRANCH_ENABLE, INST_ADDR_BUS, INST_DATA_BUS, RESP_OKAY, and the state encodings IDLE/AR/R/OUT as localparams.
- One natural sub-module: ifu_pc_reg, which holds pc and redir_pc/flush and selects RESET_PC, dnpc or pc+4. The FSM and handshake logic stay in the top module.

Test Plan:
- Reset release with arready=1 and rvalid returned 1 cycle later with rdata=32'h0000_0413: araddr=32'h8000_0000 and valid_o, pc_o=32'h8000_0000, inst_o=32'h0000_0413. After ready_i, the next araddr is 32'h8000_0004.
- IDU back-pressure (ready_i=0 for 5 cycles): valid_o, inst_o and pc_o stay stable and no new arvalid is issued. On ready_i=1, the next fetch is at pc+4.
- be=1, dnpc=32'h8000_0100 while in OUT: valid_o drops next cycle and the next araddr is 32'h8000_0100. The PC sequence shows no pc+4 fetch.
- be in R with rvalid delayed 3 cycles (dnpc=32'h8000_0200): no valid_o for the stale data and the next araddr is 32'h8000_0200.
- be while arvalid=1 and arready=0: araddr is unchanged until the handshake, the response is dropped, and the next fetch is dnpc. Two be pulses give a fetch at the last dnpc.
- rresp=2'b10 on a fetch: err_o=1 with valid_o. Also assert rst low mid-R: all outputs return to reset values the same cycle, and the first fetch after release is at 32'h8000_0000.
